dmem_store_buffered: RTL



---
 rtl/dmem_store_buffered_pkg.sv | 55 +++++
 rtl/dmem_store_buffered_store_buffer.sv | 74 +++++++
 rtl/dmem_store_buffered.sv | 91 +++++++++
 3 files changed

// File: rtl/dmem_store_buffered_pkg.sv
// Shared types and helpers for the buffered data-memory responder:
// access-type codes, the write-buffer entry layout and lane mask/extract logic.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Entries carry the full 30-bit word index so the type is independent of the
    // array size; the top zero-extends its AW-bit index into it.
    localparam int WIDX_W = 30;

    typedef struct packed {
        logic [WIDX_W-1:0] widx;
        logic [31:0]       data;
        logic [3:0]        mask;
        logic              valid;
    } wb_entry_t;

    function automatic logic [3:0] store_mask(input logic [2:0] funct3, input logic [1:0] lane);
        case (funct3)
            F3_B:    return 4'b0001 << lane;
            F3_H:    return 4'b0011 << {lane[1], 1'b0};
            F3_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_align(input logic [31:0] data, input logic [2:0] funct3,
                                                input logic [1:0] lane);
        case (funct3)
            F3_B:    return data << {lane, 3'b000};
            F3_H:    return data << {lane[1], 4'b0000};
            default: return data;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] funct3,
                                                 input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    return {{24{b[7]}}, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_BU:   return {24'b0, b};
            F3_HU:   return {16'b0, h};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_store_buffered_store_buffer.sv
// Posted-store FIFO with a combinational forwarding lookup that overlays all
// matching entries oldest to youngest, so the youngest byte wins.
module store_buffer
    import dmem_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enq,
    input  wb_entry_t         enqEntry,
    input  logic              drain,
    output wb_entry_t         headEntry,
    input  logic [WIDX_W-1:0] queryIdx,
    output logic [31:0]       fwdData,
    output logic [3:0]        fwdHit,
    output logic [PW:0]       count
);

    wb_entry_t   entryReg [DEPTH];
    logic [PW-1:0] headReg;
    logic [PW-1:0] tailReg;
    logic [PW:0]   countReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            headReg  <= '0;
            tailReg  <= '0;
            countReg <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                entryReg[k].valid <= 1'b0;
            end
        end else begin
            if (drain) begin
                headReg                <= headReg + 1'b1;
                entryReg[headReg].valid <= 1'b0;
            end
            // Enqueue is applied after drain so a full-buffer store reusing the
            // just-drained slot keeps its valid bit.
            if (enq) begin
                tailReg           <= tailReg + 1'b1;
                entryReg[tailReg] <= enqEntry;
            end
            unique case ({enq, drain})
                2'b10:   countReg <= countReg + 1'b1;
                2'b01:   countReg <= countReg - 1'b1;
                default: countReg <= countReg;
            endcase
        end
    end

    always_comb begin
        logic [PW-1:0] idx;
        idx     = '0;
        fwdData = '0;
        fwdHit  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = headReg + PW'(k);
            if (entryReg[idx].valid && entryReg[idx].widx == queryIdx) begin
                for (int b = 0; b < 4; b++) begin
                    if (entryReg[idx].mask[b]) begin
                        fwdData[8*b +: 8] = entryReg[idx].data[8*b +: 8];
                        fwdHit[b]         = 1'b1;
                    end
                end
            end
        end
    end

    assign headEntry = entryReg[headReg];
    assign count     = countReg;

endmodule

// File: rtl/dmem_store_buffered.sv
// M-stage data memory: stores post into a write buffer drained on non-load
// cycles; loads merge buffered bytes over the word array and extract in-cycle.
module dmem_store_buffered
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int WB_DEPTH  = 4,
    localparam int AW = $clog2(MEM_WORDS),
    localparam int CW = $clog2(WB_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          MemWriteM,
    input  logic          MemReadM,
    input  logic [2:0]    Funct3M,
    input  logic [31:0]   ALUResultM,
    input  logic [31:0]   WriteDataM,
    output logic [31:0]   ReadDataM,
    output logic [CW-1:0] WbCount,
    output logic          WbEmpty
);

    logic [31:0] memArray [MEM_WORDS];

    logic [1:0]        lane;
    logic [AW-1:0]     wordIdx;
    logic [WIDX_W-1:0] queryIdx;
    logic [3:0]        storeMask;
    logic              enq;
    logic              drain;
    wb_entry_t         enqEntry;
    wb_entry_t         headEntry;
    logic [31:0]       fwdData;
    logic [3:0]        fwdHit;
    logic [31:0]       arrayWord;
    logic [31:0]       mergedWord;
    logic              unusedOk;

    assign lane      = ALUResultM[1:0];
    assign wordIdx   = ALUResultM[AW+1:2];
    assign queryIdx  = {{(WIDX_W-AW){1'b0}}, wordIdx};
    assign storeMask = store_mask(Funct3M, lane);

    // Drain is suppressed during reset so discarded stores never reach the array.
    assign enq   = MemWriteM && !reset && (storeMask != 4'b0000);
    assign drain = !MemReadM && !reset && (WbCount != '0);

    assign enqEntry = '{widx:  queryIdx,
                        data:  store_align(WriteDataM, Funct3M, lane),
                        mask:  storeMask,
                        valid: 1'b1};

    store_buffer #(.DEPTH(WB_DEPTH)) u_store_buffer (
        .clk      (clk),
        .reset    (reset),
        .enq      (enq),
        .enqEntry (enqEntry),
        .drain    (drain),
        .headEntry(headEntry),
        .queryIdx (queryIdx),
        .fwdData  (fwdData),
        .fwdHit   (fwdHit),
        .count    (WbCount)
    );

    always_ff @(posedge clk) begin
        if (drain) begin
            for (int b = 0; b < 4; b++) begin
                if (headEntry.mask[b]) begin
                    memArray[headEntry.widx[AW-1:0]][8*b +: 8] <= headEntry.data[8*b +: 8];
                end
            end
        end
    end

    assign arrayWord = memArray[wordIdx];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign mergedWord[8*gi +: 8] = fwdHit[gi] ? fwdData[8*gi +: 8] : arrayWord[8*gi +: 8];
        end
    endgenerate

    assign ReadDataM = (MemReadM && !MemWriteM && !reset) ? load_extract(mergedWord, Funct3M, lane)
                                                          : 32'h0;
    assign WbEmpty   = (WbCount == '0);

    // Address bits above the array and fields the drain path never needs.
    assign unusedOk = ^{ALUResultM[31:AW+2], headEntry.valid, headEntry.widx[WIDX_W-1:AW]};

endmodule
